// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
//   arb_state_t    : arbiter FSM states
//   AXI_SIZE_4B    : ARSIZE for 32-bit beats
//   AXI_BURST_INCR : ARBURST encoding for incrementing bursts
//   AXI_LEN_W      : width of ARLEN
//   idx_width()    : bits needed to index n masters (at least 1)
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned AXI_LEN_W = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// The search starts at ptr and wraps modulo NUM_MASTERS; the first set
// request wins.
//   req     : per-master request vector
//   ptr     : index with highest priority this cycle
//   gnt_idx : index of the winner (0 when gnt_any is low)
//   gnt_any : at least one request is set
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_any
);

  logic [31:0] cand;

  // Walk from the farthest offset back to ptr so the closest request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
      cand = (32'(ptr) + 32'(k)) % 32'(NUM_MASTERS);
      if (req[IDX_W'(cand)]) begin
        gnt_idx = IDX_W'(cand);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares the AXI4 read port (AR/R) of the on-chip data RAM between
// NUM_MASTERS requesters. One whole burst is granted at a time; the
// winner's AR is forwarded to the RAM and its R beats are routed back to it.
// Optional build macro ARB_FIXED_PRIORITY_EN: lowest index always wins
// (rr_ptr held at 0); when undefined, arbitration is round-robin.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   m_araddr/m_arlen  : per-master AR payload, master i in slice i
//   m_arvalid         : per-master AR valid
//   m_arready         : per-master AR accepted (granted master only)
//   m_rdata           : read data, broadcast to all masters
//   m_rvalid/m_rlast  : R valid / last, granted master lane only
//   m_rready          : per-master R ready
//   s_ar*             : AR channel to RAM (id 0, 4-byte INCR)
//   s_r*              : R channel from RAM
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*AXI_LEN_W-1:0]  m_arlen,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_rlast,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic                              s_arid,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [AXI_LEN_W-1:0]              s_arlen,
  output logic [2:0]                        s_arsize,
  output logic [1:0]                        s_arburst,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_rlast,
  input  logic                              s_rvalid,
  output logic                              s_rready
);

  localparam int unsigned       IDX_W    = idx_width(NUM_MASTERS);
  localparam int unsigned       LEN_W    = AXI_LEN_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  grant_reg;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [LEN_W-1:0]  beat_cnt;
  logic              beat_done;
  logic              burst_end;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
  logic [LEN_W-1:0]      len_arr  [NUM_MASTERS];

  // Unpack the per-master AR payloads.
  for (genvar i = 0; i < int'(NUM_MASTERS); i++) begin : g_unpack
    assign addr_arr[i] = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]  = m_arlen[i*LEN_W +: LEN_W];
  end

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req     (m_arvalid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // A beat completes on the RAM side; the burst ends on rlast or on the
  // local beat count, whichever comes first (tolerates a late rlast).
  assign beat_done = (state == ARB_DATA) && s_rvalid && s_rready;
  assign burst_end = beat_done && (s_rlast || (beat_cnt == s_arlen));

  // Arbiter FSM with registered AR request and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      grant_reg <= '0;
      rr_ptr    <= '0;
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_reg <= pick_idx;
            s_araddr  <= addr_arr[pick_idx];
            s_arlen   <= len_arr[pick_idx];
            s_arvalid <= 1'b1;
            beat_cnt  <= '0;
            state     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (burst_end) begin
            state <= ARB_IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
            rr_ptr <= '0;
`else
            rr_ptr <= (grant_reg == LAST_IDX) ? '0 : grant_reg + IDX_W'(1);
`endif
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Handshake routing: only the granted lane ever sees ready/valid/last.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    s_rready  = 1'b0;
    case (state)
      ARB_ADDR: m_arready[grant_reg] = s_arvalid && s_arready;
      ARB_DATA: begin
        s_rready            = m_rready[grant_reg];
        m_rvalid[grant_reg] = s_rvalid;
        m_rlast[grant_reg]  = s_rlast;
      end
      default: ;
    endcase
  end

  assign m_rdata   = s_rdata;
  assign s_arid    = 1'b0;
  assign s_arsize  = AXI_SIZE_4B;
  assign s_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter (2 masters) with a behavioural RAM slave and
// per-lane scoreboards of expected {rlast, rdata} beats.
module tb_axi_read_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;

  logic              clk;
  logic              rst;
  logic [NM*AW-1:0]  m_araddr;
  logic [NM*8-1:0]   m_arlen;
  logic [NM-1:0]     m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [31:0]       m_rdata;
  logic              s_arid;
  logic [31:0]       s_araddr;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid, s_arready;
  logic [31:0]       s_rdata;
  logic              s_rlast, s_rvalid, s_rready;

  axi_read_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] pend_addr [NM][$];
  logic [7:0]  pend_len  [NM][$];
  logic [32:0] exp_q     [NM][$];
  int          ord_q[$];
  int          beats_rx[NM];
  int          stall[NM];
  bit          rand_bp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic push(input int lane, input logic [31:0] addr, input logic [7:0] len);
    pend_addr[lane].push_back(addr);
    pend_len[lane].push_back(len);
    for (int b = 0; b <= int'(len); b++)
      exp_q[lane].push_back({b == int'(len), mem_word(addr + 32'(b * 4))});
  endtask

  function automatic bit tb_busy();
    int n;
    n = 0;
    for (int i = 0; i < NM; i++) n += pend_addr[i].size() + exp_q[i].size();
    return (n != 0) || (m_arvalid != '0);
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (tb_busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < budget), 64'(1));
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, 64'({s_arvalid, s_rready, m_rvalid, m_arready}), 64'(0));
  endtask

  task automatic wait_beats(input string tag, input int lane, input int target);
    int n = 0;
    while (beats_rx[lane] < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 300), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    ord_q.delete();
    @(negedge clk);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'(0));
    chk("rst_s_rready",  64'(s_rready),  64'(0));
    chk("rst_m_arready", 64'(m_arready), 64'(0));
    chk("rst_m_rvalid",  64'(m_rvalid),  64'(0));
    chk("rst_m_rlast",   64'(m_rlast),   64'(0));
    chk("rst_ar_consts", 64'({s_arid, s_arsize, s_arburst}), 64'({1'b0, 3'b010, 2'b01}));
    #2 rst = 1'b1;
  endtask

  // Master side: sample at negedge, drive after posedge.
  initial begin
    bit   arhs [NM];
    int   g;
    logic [32:0] e;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    for (int i = 0; i < NM; i++) begin beats_rx[i] = 0; stall[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) begin
        arhs[i] = m_arvalid[i] && m_arready[i];
        if (m_rvalid[i] && m_rready[i]) begin
          chk($sformatf("beat_expected_lane%0d", i), 64'(exp_q[i].size() != 0), 64'(1));
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("beat_last_data_lane%0d", i), 64'({m_rlast[i], m_rdata}), 64'(e));
          end
          beats_rx[i]++;
        end
      end
      if (m_arready != '0 && !(s_arvalid && s_arready))
        chk("arready_without_ram_hs", 64'(m_arready), 64'(0));
      if (s_arvalid && s_arready) begin
        g = -1;
        for (int i = 0; i < NM; i++) if (m_arready[i]) g = i;
        chk("ar_onehot", 64'($countones(m_arready)), 64'(1));
        if (ord_q.size() != 0) chk("grant_order", 64'(g), 64'(ord_q.pop_front()));
        if (g >= 0) begin
          chk("fwd_araddr", 64'(s_araddr), 64'(m_araddr[g*AW +: AW]));
          chk("fwd_arlen",  64'(s_arlen),  64'(m_arlen[g*8 +: 8]));
        end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        m_arvalid = '0;
        m_rready  = '0;
        for (int i = 0; i < NM; i++) begin
          pend_addr[i].delete(); pend_len[i].delete(); exp_q[i].delete(); stall[i] = 0;
        end
      end else begin
        for (int i = 0; i < NM; i++) begin
          if (arhs[i]) m_arvalid[i] = 1'b0;
          if (!m_arvalid[i] && pend_addr[i].size() != 0) begin
            m_araddr[i*AW +: AW] = pend_addr[i].pop_front();
            m_arlen[i*8 +: 8]    = pend_len[i].pop_front();
            m_arvalid[i]         = 1'b1;
          end
          if (stall[i] > 0) begin
            m_rready[i] = 1'b0;
            stall[i]--;
          end else begin
            m_rready[i] = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
        end
      end
    end
  end

  // RAM slave model: one burst at a time, random ready/valid timing.
  initial begin
    bit          ar_hs, r_hs, busy;
    logic [31:0] cap_addr, baddr;
    logic [7:0]  cap_len, blen;
    int          beat;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    busy = 1'b0; baddr = '0; blen = '0; beat = 0; cap_addr = '0; cap_len = '0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      if (ar_hs) begin
        chk("one_outstanding", 64'(busy && !(r_hs && beat >= int'(blen))), 64'(0));
        cap_addr = s_araddr;
        cap_len  = s_arlen;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        busy = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
      end else begin
        if (busy && r_hs) begin
          beat++;
          if (beat > int'(blen)) busy = 1'b0;
        end
        if (ar_hs) begin
          busy = 1'b1; baddr = cap_addr; blen = cap_len; beat = 0;
        end
        if (busy) begin
          if (!s_rvalid || r_hs) s_rvalid = ($urandom_range(0, 3) != 0);
          s_rdata = mem_word(baddr + 32'(beat * 4));
          s_rlast = (beat == int'(blen));
        end else begin
          s_rvalid = 1'b0;
          s_rlast  = 1'b0;
        end
        s_arready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    int b0, b1;
    rst = 1'b0;
    rand_bp = 1'b0;
    do_reset();

    // Single master, 4-beat burst, with arbitration latency.
    @(negedge clk);
    b0 = beats_rx[0]; b1 = beats_rx[1];
    push(0, 32'h100, 8'd3);
    ord_q.push_back(0);
    @(negedge clk);
    chk("lat_arvalid_low", 64'(s_arvalid), 64'(0));
    @(negedge clk);
    chk("lat_arvalid_high", 64'(s_arvalid), 64'(1));
    chk("t1_araddr", 64'(s_araddr), 64'(32'h100));
    chk("t1_arlen",  64'(s_arlen),  64'(3));
    wait_idle("t1_drain", 300);
    chk("t1_lane0_beats", 64'(beats_rx[0] - b0), 64'(4));
    chk("t1_lane1_beats", 64'(beats_rx[1] - b1), 64'(0));

    // Contention after reset, then rotation.
    do_reset();
    @(negedge clk);
    push(0, 32'h200, 8'd1); push(1, 32'h280, 8'd1);
    ord_q.push_back(0); ord_q.push_back(1);
    wait_idle("t2a_drain", 300);
    @(negedge clk);
    push(0, 32'h2C0, 8'd0);
    ord_q.push_back(0);
    wait_idle("t2b_drain", 300);
    @(negedge clk);
    push(0, 32'h300, 8'd2); push(1, 32'h340, 8'd2);
`ifdef ARB_FIXED_PRIORITY_EN
    ord_q.push_back(0); ord_q.push_back(1);
`else
    ord_q.push_back(1); ord_q.push_back(0);
`endif
    wait_idle("t2c_drain", 300);
    chk("t2_order_consumed", 64'(ord_q.size()), 64'(0));

    // Backpressure on lane 1 for 3 cycles mid-burst.
    @(negedge clk);
    b1 = beats_rx[1];
    push(1, 32'h800, 8'd7);
    ord_q.push_back(1);
    wait_beats("t3_mid", 1, b1 + 2);
    stall[1] = 3;
    repeat (3) begin
      @(negedge clk);
      chk("t3_s_rready_low", 64'(s_rready), 64'(0));
    end
    wait_idle("t3_drain", 300);
    chk("t3_beats", 64'(beats_rx[1] - b1), 64'(8));

    // Single-beat burst on lane 1 while lane 0 waits.
    @(negedge clk);
    b1 = beats_rx[1];
    push(1, 32'hA00, 8'd0);
    ord_q.push_back(1); ord_q.push_back(0);
    @(negedge clk);
    push(0, 32'hA40, 8'd1);
    begin
      int n = 0;
      while (exp_q[1].size() != 0 && n < 100) begin
        @(negedge clk);
        chk("t4_m0_arready_low", 64'(m_arready[0]), 64'(0));
        n++;
      end
      chk("t4_m1_done", 64'(n < 100), 64'(1));
    end
    wait_idle("t4_drain", 300);
    chk("t4_m1_beats", 64'(beats_rx[1] - b1), 64'(1));

    // Reset in the middle of a data phase, then a normal burst.
    @(negedge clk);
    b0 = beats_rx[0];
    push(0, 32'hC00, 8'd7);
    wait_beats("t5_mid", 0, b0 + 2);
    do_reset();
    @(negedge clk);
    b1 = beats_rx[1];
    push(1, 32'hD00, 8'd3);
    ord_q.push_back(1);
    wait_idle("t5_drain", 300);
    chk("t5_beats", 64'(beats_rx[1] - b1), 64'(4));

    // Alternating 8-beat bursts with random timing everywhere.
    @(negedge clk);
    rand_bp = 1'b1;
    b0 = beats_rx[0]; b1 = beats_rx[1];
    for (int k = 0; k < 100; k++)
      push(k % 2, 32'($urandom_range(0, 32'hFFFF)) << 5, 8'd7);
    wait_idle("t6_drain", 30000);
    rand_bp = 1'b0;
    chk("t6_beats", 64'((beats_rx[0] - b0) + (beats_rx[1] - b1)), 64'(800));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
